fetch_queue: RTL

//  Instruction prefetch buffer between InstructionMemory and the IF_ID register.

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential fetches and
// buffers returned words with their PC+4 tag, presenting a show-ahead head to IF_ID.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     hold,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     valid_out,
  output logic [31:0]              instr_out,
  output logic [31:0]              pc_plus4_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = PtrW + 2;

  localparam logic [PtrW-1:0] PtrOne   = {{(PtrW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [OccW-1:0] OccDepth = OccW'(DEPTH);

  logic [31:0]     fetchPcQ, fetchPcD;
  logic [31:0]     tagQ, tagD;
  logic            inflightQ, inflightD;
  logic [PtrW-1:0] rdPtrQ, rdPtrD;
  logic [PtrW-1:0] wrPtrQ, wrPtrD;
  logic [CntW-1:0] countQ, countD;

  logic [31:0] instrMem [DEPTH];
  logic [31:0] tagMem   [DEPTH];

  logic [OccW-1:0] occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic            headValid;

  // In-flight fetch reserves a slot so a returning word always has room.
  assign occupancy = OccW'(countQ) + OccW'(inflightQ);
  assign issue     = !reset && !redirect && (occupancy < OccDepth);
  assign push      = inflightQ && !redirect && !reset;
  assign headValid = (countQ != '0);
  assign pop       = headValid && !hold && !redirect && !reset;

  always_comb begin
    fetchPcD  = fetchPcQ;
    tagD      = tagQ;
    inflightD = issue;
    rdPtrD    = rdPtrQ;
    wrPtrD    = wrPtrQ;
    countD    = countQ;

    if (redirect) begin
      fetchPcD = redirect_pc;
      rdPtrD   = wrPtrQ;
      countD   = '0;
    end else begin
      if (issue) begin
        fetchPcD = fetchPcQ + 32'd4;
        tagD     = fetchPcQ + 32'd4;
      end
      if (push) begin
        wrPtrD = wrPtrQ + PtrOne;
      end
      if (pop) begin
        rdPtrD = rdPtrQ + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   countD = countQ + CntOne;
        2'b01:   countD = countQ - CntOne;
        default: countD = countQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPcQ  <= RESET_PC;
      tagQ      <= '0;
      inflightQ <= 1'b0;
      rdPtrQ    <= '0;
      wrPtrQ    <= '0;
      countQ    <= '0;
    end else begin
      fetchPcQ  <= fetchPcD;
      tagQ      <= tagD;
      inflightQ <= inflightD;
      rdPtrQ    <= rdPtrD;
      wrPtrQ    <= wrPtrD;
      countQ    <= countD;
    end
  end

  // Storage needs no reset: entries are only observed through countQ.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtrQ] <= imem_rdata;
      tagMem[wrPtrQ]   <= tagQ;
    end
  end

  always_comb begin
    imem_req     = issue;
    imem_addr    = reset ? 32'h0 : fetchPcQ;
    valid_out    = headValid && !reset;
    instr_out    = 32'h0;
    pc_plus4_out = 32'h0;
    count        = reset ? '0 : countQ;
    if (valid_out) begin
      instr_out    = instrMem[rdPtrQ];
      pc_plus4_out = tagMem[rdPtrQ];
    end
  end

endmodule
